// File: rtl/param_ram_pkg.sv
// Shared definitions for the parameterised RAM block: controller state
// encoding and default geometry.
package param_ram_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 6;

    // CLEAR: zeroing sweep in progress; IDLE: normal read/write access
    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

endpackage

// File: rtl/param_ram_array.sv
// Plain synchronous storage: one write port and one registered read port.
// No reset on the array or the read register; zeroing is the controller's job.
module param_ram_array #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_reg;

    // Write port and registered read port; a same-address read returns the old word
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/param_ram.sv
// Parameterised single-port-address RAM with a self-clearing sweep.
// After reset (or a clear request) the controller spends exactly DEPTH cycles
// writing zero to every word while busy is high; accesses in that window are
// discarded and flagged on drop.
// Build option: define RAM_BYPASS_EN for write-first read-during-write
// (out shows the new data); otherwise reads are read-first (old data).
module param_ram
    import param_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              read,
    input  logic              write,
    input  logic              clear,
    input  logic [ADDR_W-1:0] add,
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              busy,
    output logic              drop
);

    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

    state_t            state_reg;
    logic [ADDR_W-1:0] ptr_reg;
    logic              out_valid_reg;
    logic              drop_reg;
    // Masks the (unreset) array read register until the first accepted read
    logic              out_zero_reg;

    logic              idle;
    logic              acc_req;
    logic              clr_go;
    logic              rd_go;
    logic              wr_go;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;

    assign idle    = (state_reg == IDLE);
    assign acc_req = en & (read | write | clear);
    // Clear wins over read/write in the same cycle
    assign clr_go  = idle & en & clear;
    assign rd_go   = idle & en & read  & ~clear;
    assign wr_go   = idle & en & write & ~clear;

    // The sweep owns the write port while clearing
    assign arr_we    = ~idle | wr_go;
    assign arr_waddr = idle ? add : ptr_reg;
    assign arr_wdata = idle ? in  : '0;

    param_ram_array #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .waddr(arr_waddr),
        .wdata(arr_wdata),
        .re   (rd_go),
        .raddr(add),
        .rdata(arr_rdata)
    );

    // Controller FSM: sweep counter, access acceptance and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= CLEAR;
            ptr_reg       <= '0;
            out_valid_reg <= 1'b0;
            drop_reg      <= 1'b0;
            out_zero_reg  <= 1'b1;
        end else begin
            out_valid_reg <= rd_go;
            drop_reg      <= (~idle & acc_req) | (clr_go & (read | write));
            if (rd_go) begin
                out_zero_reg <= 1'b0;
            end
            case (state_reg)
                CLEAR: begin
                    // Natural wrap leaves ptr at 0 on exit
                    ptr_reg <= ptr_reg + ADDR_W'(1);
                    if (ptr_reg == PTR_LAST) begin
                        state_reg <= IDLE;
                    end
                end
                IDLE: begin
                    if (clr_go) begin
                        state_reg <= CLEAR;
                        ptr_reg   <= '0;
                    end
                end
                default: begin
                    state_reg <= CLEAR;
                    ptr_reg   <= '0;
                end
            endcase
        end
    end

`ifdef RAM_BYPASS_EN
    logic              byp_reg;
    logic [DATA_W-1:0] byp_data_reg;

    // Write-first: remember write data when a read and write hit together
    // (the address is shared, so a simultaneous pair is always same-address)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp_reg      <= 1'b0;
            byp_data_reg <= '0;
        end else if (rd_go) begin
            byp_reg      <= wr_go;
            byp_data_reg <= in;
        end
    end

    assign byp_hit  = byp_reg;
    assign byp_data = byp_data_reg;
`else
    assign byp_hit  = 1'b0;
    assign byp_data = '0;
`endif

    assign out       = out_zero_reg ? '0 : (byp_hit ? byp_data : arr_rdata);
    assign out_valid = out_valid_reg;
    assign busy      = (state_reg == CLEAR);
    assign drop      = drop_reg;

endmodule

// File: tb/tb_param_ram.sv
// Randomised scoreboard bench for param_ram. The driver updates a
// behavioural model and queues the expected post-edge response; a monitor
// pops one entry per cycle and compares. A small 8x8 instance checks the
// sweep length scales with ADDR_W.
module tb_param_ram;

    localparam int DW    = 16;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0, read = 1'b0, write = 1'b0, clear = 1'b0;
    logic [AW-1:0] add = '0;
    logic [DW-1:0] in_d = '0;
    logic [DW-1:0] out;
    logic          out_valid, busy, drop;

    logic          s_rst = 1'b1;
    logic          s_en = 1'b0, s_read = 1'b0, s_write = 1'b0, s_clear = 1'b0;
    logic [2:0]    s_add = '0;
    logic [7:0]    s_in = '0;
    logic [7:0]    s_out;
    logic          s_out_valid, s_busy, s_drop;

    always #5 clk = ~clk;

    param_ram #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .en(en), .read(read), .write(write), .clear(clear),
        .add(add), .in(in_d), .out(out), .out_valid(out_valid), .busy(busy), .drop(drop)
    );

    param_ram #(.DATA_W(8), .ADDR_W(3)) dut_small (
        .clk(clk), .rst(s_rst), .en(s_en), .read(s_read), .write(s_write), .clear(s_clear),
        .add(s_add), .in(s_in), .out(s_out), .out_valid(s_out_valid), .busy(s_busy), .drop(s_drop)
    );

    typedef struct {
        bit            busy;
        bit            drop;
        bit            valid;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model_mem [DEPTH];
    int            rem;          // sweep edges still to come
    int            compared   = 0;
    int            mismatched = 0;
    bit            busy_seen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    // One clock of stimulus; the model predicts the state after the next edge
    task automatic cycle(input bit e, input bit r, input bit w, input bit c,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t x;
        @(negedge clk);
        busy_seen = busy;
        en = e; read = r; write = w; clear = c; add = a; in_d = d;
        x.valid = 1'b0; x.data = '0; x.drop = 1'b0;
        if (rem > 0) begin
            x.drop = e && (r || w || c);
            rem--;
        end else if (e && c) begin
            x.drop = r || w;
            model_zero();
            rem = DEPTH;
        end else if (e) begin
            if (r) begin
                x.valid = 1'b1;
                x.data  = model_mem[a];
`ifdef RAM_BYPASS_EN
                if (w) x.data = d;
`endif
            end
            if (w) model_mem[a] = d;
        end
        x.busy = (rem > 0);
        exp_q.push_back(x);
        $display("cyc en=%0b r=%0b w=%0b c=%0b add=%0d in=%0h exp_valid=%0b exp_data=%0h exp_busy=%0b exp_drop=%0b",
                 e, r, w, c, a, d, x.valid, x.data, x.busy, x.drop);
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Asserted between edges, after the monitor has drained the queue
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        en = 1'b0; read = 1'b0; write = 1'b0; clear = 1'b0;
        #1;
        check("rst_out", out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 1);
        check("rst_drop", drop, 0);
        repeat (2) @(posedge clk);
        #2;
        check("rst_busy_held", busy, 1);
        rst = 1'b0;
        rem = DEPTH;
        model_zero();
    endtask

    // Count cycles with busy high, starting at the current point in the sweep
    task automatic count_sweep(output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            idle_cycle();
            if (!busy_seen) break;
            n++;
        end
    endtask

    // Monitor: compare the DUT to the expectation queued for this edge
    always @(posedge clk) begin : monitor
        exp_t x;
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check("busy", busy, x.busy);
            check("drop", drop, x.drop);
            check("out_valid", out_valid, x.valid);
            if (x.valid) check("out", out, x.data);
        end
    end

    initial begin : stimulus
        int n;
        model_zero();
        rem = DEPTH;

        // Reset then sweep length, then read of a cleared word
        do_reset();
        count_sweep(n);
        check("sweep_len", n, DEPTH);
        cycle(1, 1, 0, 0, 6'd2, '0);

        // Eight writes spread over the array, read back in order
        for (int k = 0; k < 8; k++) cycle(1, 0, 1, 0, AW'(2 + 8 * k), DW'(k + 1));
        for (int k = 0; k < 8; k++) cycle(1, 1, 0, 0, AW'(2 + 8 * k), '0);

        // Overwrite then read
        cycle(1, 0, 1, 0, 6'd32, 16'd9);
        cycle(1, 0, 1, 0, 6'd32, 16'd10);
        cycle(1, 1, 0, 0, 6'd32, '0);

        // Read-during-write, then a plain read
        cycle(1, 1, 1, 0, 6'd32, 16'd11);
        cycle(1, 1, 0, 0, 6'd32, '0);
        idle_cycle();

        // Clear with data present; write during the sweep is dropped
        cycle(1, 0, 0, 1, '0, '0);
        cycle(1, 0, 1, 0, 6'd5, 16'hAAAA);
        count_sweep(n);
        check("clear_sweep_len", n + 1, DEPTH);
        cycle(1, 1, 0, 0, 6'd2, '0);
        cycle(1, 1, 0, 0, 6'd32, '0);
        cycle(1, 1, 0, 0, 6'd5, '0);

        // Reset at sweep cycle 20 restarts the full sweep
        do_reset();
        repeat (20) idle_cycle();
        do_reset();
        count_sweep(n);
        check("restart_sweep_len", n, DEPTH);

        // Reset in the middle of an accepted read
        cycle(1, 0, 1, 0, 6'd7, 16'h1234);
        cycle(1, 1, 0, 0, 6'd7, '0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        en = 1'b0; read = 1'b0;
        #1;
        check("midread_out_valid", out_valid, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        rem = DEPTH;
        model_zero();
        count_sweep(n);
        check("midread_sweep_len", n, DEPTH);

        // Randomised traffic including occasional clears
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(7) != 0), $urandom_range(1), $urandom_range(1),
                  ($urandom_range(63) == 0), AW'($urandom), DW'($urandom));
        end
        repeat (3) idle_cycle();

        // Small geometry: 8-word sweep and a basic write/read
        @(posedge clk);
        #2;
        s_rst = 1'b0;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!s_busy) break;
            n++;
        end
        check("small_sweep_len", n, 8);
        s_en = 1'b1; s_write = 1'b1; s_add = 3'd3; s_in = 8'h5A;
        @(negedge clk);
        s_write = 1'b0; s_read = 1'b1;
        @(posedge clk);
        #1;
        check("small_out_valid", s_out_valid, 1);
        check("small_out", s_out, 8'h5A);
        @(negedge clk);
        s_add = 3'd4;
        @(posedge clk);
        #1;
        check("small_out_zero", s_out, 8'h00);
        @(negedge clk);
        s_read = 1'b0; s_en = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
